// File: rtl/dataout_buf_0_if.sv
// Core-to-router transmit bundle for the node 0 flit buffer.
// Flit on dataout is {payload, dest}; master drives the enqueue side and out_ready.
interface dataout_buf_0_if #(
  parameter int LVL_W = 6
);
  logic             wr_en;
  logic [15:0]      payload;
  logic [3:0]       dest;
  logic             out_ready;
  logic             out_valid;
  logic [19:0]      dataout;
  logic             state;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic [15:0]      tx_count;

  modport master (
    output wr_en, payload, dest, out_ready,
    input  out_valid, dataout, state, empty, level, overflow, tx_count
  );

  modport slave (
    input  wr_en, payload, dest, out_ready,
    output out_valid, dataout, state, empty, level, overflow, tx_count
  );
endinterface

// File: rtl/dataout_buf_0.sv
// Transmit flit FIFO with registered head stage; 1-cycle write-to-valid, 1 flit/cycle sustained.
// Router stalls hold dataout; writes while full are dropped and flagged in sticky overflow.
module dataout_buf_0 #(
  parameter int DEPTH = 40,
  parameter int LVL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  dataout_buf_0_if.slave    bus
);

  localparam logic [LVL_W-1:0] L_DEPTH = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] L_LAST  = LVL_W'(DEPTH - 1);

  logic [19:0]      r_mem [DEPTH];
  logic [LVL_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_out_vld;
  logic [19:0]      r_out_dat;
  logic             r_overflow;
  logic [15:0]      r_tx_count;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_pop;
  logic [LVL_W-1:0] w_mem_cnt;
  logic             w_mem_empty;
  logic             w_load;
  logic             w_bypass;
  logic             w_mem_wr;
  logic             w_mem_rd;
  logic [19:0]      w_wr_flit;

  function automatic logic [LVL_W-1:0] ptr_inc(input logic [LVL_W-1:0] p);
    return (p == L_LAST) ? '0 : p + LVL_W'(1);
  endfunction

  assign w_full      = (r_level == L_DEPTH);
  assign w_empty     = (r_level == '0);
  assign w_wr_acc    = bus.wr_en && !w_full;
  assign w_pop       = r_out_vld && bus.out_ready;
  assign w_wr_flit   = {bus.payload, bus.dest};
  // Level counts the head register too, so the RAM holds level minus the head.
  assign w_mem_cnt   = r_level - LVL_W'(r_out_vld);
  assign w_mem_empty = (w_mem_cnt == '0);
  assign w_load      = !r_out_vld || w_pop;
  assign w_bypass    = w_load && w_mem_empty;
  assign w_mem_wr    = w_wr_acc && !w_bypass && !rst;
  assign w_mem_rd    = w_load && !w_mem_empty;

  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= w_wr_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_overflow <= 1'b0;
      r_tx_count <= '0;
    end else begin
      if (bus.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_tx_count <= r_tx_count + 16'd1;
      end
      if (w_mem_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      // Head refills from RAM first; an empty RAM lets an incoming write go straight to the head.
      if (w_load) begin
        if (w_mem_rd) begin
          r_out_vld <= 1'b1;
          r_out_dat <= r_mem[r_rd_ptr];
          r_rd_ptr  <= ptr_inc(r_rd_ptr);
        end else if (w_wr_acc) begin
          r_out_vld <= 1'b1;
          r_out_dat <= w_wr_flit;
        end else begin
          r_out_vld <= 1'b0;
          r_out_dat <= '0;
        end
      end
      unique case ({w_wr_acc, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.dataout   = r_out_dat;
  assign bus.state     = w_full;
  assign bus.empty     = w_empty;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;
  assign bus.tx_count  = r_tx_count;

endmodule

// File: tb/tb_dataout_buf_0.sv
// Scoreboard bench for dataout_buf_0: queue reference model plus negedge monitor.
module tb_dataout_buf_0;

  localparam int DEPTH = 40;
  localparam int LVL_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dataout_buf_0_if #(.LVL_W(LVL_W)) bus ();

  dataout_buf_0 #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [19:0] exp_q[$];
  int          m_level = 0;
  bit          m_ovf   = 1'b0;
  logic [15:0] m_tx    = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pre-edge level decides acceptance; out_valid mirrors a nonzero level.
  always @(posedge clk) begin
    bit acc;
    bit pop;
    if (rst) begin
      m_level = 0;
      m_ovf   = 1'b0;
      m_tx    = 16'h0;
      exp_q.delete();
    end else begin
      acc = bus.wr_en && (m_level < DEPTH);
      pop = (m_level != 0) && bus.out_ready;
      if (bus.wr_en && !acc) m_ovf = 1'b1;
      if (acc) exp_q.push_back({bus.payload, bus.dest});
      m_level = m_level + int'(acc) - int'(pop);
      if (pop) m_tx = m_tx + 16'd1;
    end
  end

  logic        prev_stall = 1'b0;
  logic [19:0] prev_dat   = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_level != 0));
      chk("level", 32'(bus.level), 32'(m_level));
      chk("state", 32'(bus.state), 32'(m_level == DEPTH));
      chk("empty", 32'(bus.empty), 32'(m_level == 0));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("tx_count", 32'(bus.tx_count), 32'(m_tx));
      if (prev_stall && bus.out_valid) chk("stall_hold", 32'(bus.dataout), 32'(prev_dat));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 32'(0), 32'(1));
        end else begin
          chk("dataout", 32'(bus.dataout), 32'(exp_q[0]));
          if (bus.out_ready && !rst) void'(exp_q.pop_front());
        end
      end else begin
        chk("dataout_idle", 32'(bus.dataout), 32'(0));
      end
      prev_stall = bus.out_valid && !bus.out_ready && !rst;
      prev_dat   = bus.dataout;
    end
  end

  task automatic drive(input logic wr, input logic [15:0] p, input logic [3:0] d,
                       input logic rdy, input logic rs = 1'b0);
    bus.wr_en     = wr;
    bus.payload   = p;
    bus.dest      = d;
    bus.out_ready = rdy;
    rst           = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 16'(i), 4'(i), 1'b0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.payload = '0; bus.dest = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    mon_en = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dataout", 32'(bus.dataout), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_tx_count", 32'(bus.tx_count), 32'd0);

    // Single flit, stalled then popped.
    drive(1'b1, 16'hA5C3, 4'h2, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_dataout", 32'(bus.dataout), 32'hA5C32);
    chk("t1_level", 32'(bus.level), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      chk("t1_stall", 32'(bus.dataout), 32'hA5C32);
    end
    drive(1'b0, 16'h0, 4'h0, 1'b1);
    chk("t1_tx", 32'(bus.tx_count), 32'd1);
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_valid_off", 32'(bus.out_valid), 32'd0);

    // Fill to capacity, overflow, drain in order.
    do_reset();
    fill(DEPTH);
    chk("t2_full", 32'(bus.state), 32'd1);
    chk("t2_level", 32'(bus.level), 32'(DEPTH));
    drive(1'b1, 16'hDEAD, 4'hF, 1'b0);
    chk("t2_overflow", 32'(bus.overflow), 32'd1);
    chk("t2_level_hold", 32'(bus.level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      logic [19:0] e;
      e = {16'(i), 4'(i)};
      chk("t2_order", 32'(bus.dataout), 32'(e));
      drive(1'b0, 16'h0, 4'h0, 1'b1);
    end
    chk("t2_tx", 32'(bus.tx_count), 32'(DEPTH));
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // Full buffer: simultaneous write and pop rejects the write.
    do_reset();
    fill(DEPTH);
    drive(1'b1, 16'hBEEF, 4'h7, 1'b1);
    chk("t3_overflow", 32'(bus.overflow), 32'd1);
    chk("t3_level", 32'(bus.level), 32'(DEPTH - 1));
    chk("t3_next", 32'(bus.dataout), 32'h00011);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 16'h0, 4'h0, 1'b1);

    // Streaming at full rate across pointer wrap.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 4'(i), 1'b1);
      chk("t4_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_level", 32'(bus.level), 32'd1);
    end
    drive(1'b0, 16'h0, 4'h0, 1'b1);
    chk("t4_tx", 32'(bus.tx_count), 32'd100);

    // Reset in the middle of traffic.
    do_reset();
    fill(10);
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 4'h0, 1'b1);
    drive(1'b1, 16'h5555, 4'h5, 1'b1, 1'b1);
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_dataout", 32'(bus.dataout), 32'd0);
    chk("t5_level", 32'(bus.level), 32'd0);
    chk("t5_empty", 32'(bus.empty), 32'd1);
    chk("t5_overflow", 32'(bus.overflow), 32'd0);
    chk("t5_tx", 32'(bus.tx_count), 32'd0);
    drive(1'b1, 16'h7777, 4'h9, 1'b0);
    chk("t5_first", 32'(bus.dataout), 32'h77779);

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 16'h0, 4'h0, 1'b1);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_empty", 32'(bus.empty), 32'd1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
